// File: rtl/core_test_pkg.sv
// Shared encodings and widths for the core test sequencer and its
// expected-value store.
package core_test_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int MISM_W  = 6;

  typedef enum logic [1:0] {
    CMD_IMEM   = 2'd0,
    CMD_PRESET = 2'd1,
    CMD_EXPECT = 2'd2,
    CMD_START  = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/core_test_sequencer_expect_store.sv
// Expected register values plus a valid mask.
// One write port and one combinational read port driven by the check sweep.
module expect_store
  import core_test_pkg::*;
#(
  parameter int DW    = XLEN,
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [DW-1:0]     rdata,
  output logic              rvalid
);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] mask;

  // Data needs no reset: an entry only counts once its mask bit is set.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask <= '0;
    end else if (we) begin
      mask[waddr] <= 1'b1;
    end
  end

  assign rdata  = mem[raddr];
  assign rvalid = mask[raddr];

endmodule

// File: rtl/core_test_sequencer.sv
// Harness controller: loads a program, presets registers, runs the core
// for a bounded budget or until a halt PC, then checks the register file.
module core_test_sequencer #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int IMEM_AW    = 8,
  parameter int NUM_REGS   = 32,
  parameter int MAX_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [IMEM_AW:0]   cmd_addr,
  input  logic [XLEN-1:0]    cmd_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic [4:0]         rf_raddr,
  input  logic [XLEN-1:0]    rf_rdata,
  output logic               core_reset,
  output logic               core_run,
  input  logic [XLEN-1:0]    pc,
  output logic               done,
  output logic               pass,
  output logic               halted,
  output logic               load_err,
  output logic [5:0]         mismatch_count,
  output logic [4:0]         first_fail_reg
);

  import core_test_pkg::*;

  localparam logic [IMEM_AW:0] DEPTH_LIM = (IMEM_AW+1)'(IMEM_DEPTH);
  localparam logic [4:0]       LAST_REG  = 5'(NUM_REGS - 1);

  state_t            state;
  logic [XLEN-1:0]   budget;
  logic [XLEN-1:0]   run_cnt;
  logic [IMEM_AW:0]  halt_idx;

  logic              accept;
  logic              exp_we;
  logic [XLEN-1:0]   exp_data;
  logic              exp_valid;
  logic              halt_hit;
  logic              reg_fail;
  logic [5:0]        mism_next;
  logic              unused_bits;

  assign accept = (state == ST_LOAD) && cmd_valid && cmd_ready;
  assign exp_we = accept && (cmd_type == CMD_EXPECT);

  expect_store #(
    .DW    (XLEN),
    .DEPTH (NUM_REGS)
  ) u_expect_store (
    .clk    (clk),
    .reset  (reset),
    .we     (exp_we),
    .waddr  (cmd_addr[REG_AW-1:0]),
    .wdata  (cmd_data),
    .raddr  (rf_raddr),
    .rdata  (exp_data),
    .rvalid (exp_valid)
  );

  assign halt_hit  = (halt_idx < DEPTH_LIM) &&
                     (pc[IMEM_AW+1:2] == halt_idx[IMEM_AW-1:0]);
  assign reg_fail  = exp_valid && (rf_rdata != exp_data);
  assign mism_next = (reg_fail && (mismatch_count != 6'd63)) ?
                     mismatch_count + 6'd1 : mismatch_count;
  assign unused_bits = ^{pc[XLEN-1:IMEM_AW+2], pc[1:0]};

  // Write strobes are single-cycle pulses; everything else holds until changed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_LOAD;
      cmd_ready      <= 1'b0;
      core_reset     <= 1'b1;
      core_run       <= 1'b0;
      imem_we        <= 1'b0;
      imem_addr      <= '0;
      imem_wdata     <= '0;
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      rf_raddr       <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      halted         <= 1'b0;
      load_err       <= 1'b0;
      mismatch_count <= '0;
      first_fail_reg <= '0;
      budget         <= '0;
      run_cnt        <= '0;
      halt_idx       <= '0;
    end else begin
      imem_we <= 1'b0;
      rf_we   <= 1'b0;
      unique case (state)
        ST_LOAD: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            unique case (cmd_t'(cmd_type))
              CMD_IMEM: begin
                if (cmd_addr < DEPTH_LIM) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= cmd_addr[IMEM_AW-1:0];
                  imem_wdata <= cmd_data;
                end else begin
                  load_err <= 1'b1;
                end
              end
              CMD_PRESET: begin
                if (cmd_addr[4:0] != 5'd0) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= cmd_addr[4:0];
                  rf_wdata <= cmd_data;
                end
              end
              CMD_EXPECT: begin
              end
              CMD_START: begin
                budget     <= (cmd_data == '0) ? XLEN'(MAX_CYCLES) : cmd_data;
                halt_idx   <= cmd_addr;
                run_cnt    <= '0;
                cmd_ready  <= 1'b0;
                core_reset <= 1'b0;
                core_run   <= 1'b1;
                state      <= ST_RUN;
              end
            endcase
          end
        end
        ST_RUN: begin
          run_cnt <= run_cnt + XLEN'(1);
          if (halt_hit || (run_cnt + XLEN'(1) == budget)) begin
            halted         <= halt_hit;
            core_run       <= 1'b0;
            rf_raddr       <= '0;
            mismatch_count <= '0;
            state          <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          mismatch_count <= mism_next;
          // Count is still zero only before the first masked failure.
          if (reg_fail && (mismatch_count == 6'd0)) first_fail_reg <= rf_raddr;
          rf_raddr <= rf_raddr + 5'd1;
          if (rf_raddr == LAST_REG) begin
            done  <= 1'b1;
            pass  <= (mism_next == 6'd0) && !load_err;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_test_sequencer.sv
// Directed bench for core_test_sequencer with a tiny ADDI/ORI core model.
module tb_core_test_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'd0;
  logic [8:0]  cmd_addr = 9'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        core_reset;
  logic        core_run;
  logic [31:0] pc;
  logic        done;
  logic        pass;
  logic        halted;
  logic        load_err;
  logic [5:0]  mismatch_count;
  logic [4:0]  first_fail_reg;

  int vec_count = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  core_test_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_type       (cmd_type),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .rf_raddr       (rf_raddr),
    .rf_rdata       (rf_rdata),
    .core_reset     (core_reset),
    .core_run       (core_run),
    .pc             (pc),
    .done           (done),
    .pass           (pass),
    .halted         (halted),
    .load_err       (load_err),
    .mismatch_count (mismatch_count),
    .first_fail_reg (first_fail_reg)
  );

  // Minimal core: executes ADDI and ORI only, everything else is a no-op.
  logic [31:0] imem_m [256];
  logic [31:0] regs_m [32];
  logic [31:0] pc_m;
  logic        model_clear = 1'b1;
  int          run_count;
  int          x0_writes;
  logic [31:0] cur_ins;
  logic [31:0] cur_imm;

  assign cur_ins  = imem_m[pc_m[9:2]];
  assign cur_imm  = {{20{cur_ins[31]}}, cur_ins[31:20]};
  assign rf_rdata = regs_m[rf_raddr];
  assign pc       = pc_m;

  always @(posedge clk) begin
    if (model_clear) begin
      for (int i = 0; i < 256; i++) imem_m[i] <= 32'd0;
      for (int i = 0; i < 32; i++) regs_m[i] <= 32'd0;
      pc_m      <= 32'd0;
      run_count <= 0;
      x0_writes <= 0;
    end else begin
      if (imem_we) imem_m[imem_addr] <= imem_wdata;
      if (rf_we) begin
        if (rf_waddr == 5'd0) x0_writes <= x0_writes + 1;
        else regs_m[rf_waddr] <= rf_wdata;
      end
      if (core_run) run_count <= run_count + 1;
      if (core_reset) begin
        pc_m <= 32'd0;
      end else if (core_run) begin
        if (cur_ins[6:0] == 7'h13 && cur_ins[11:7] != 5'd0) begin
          if (cur_ins[14:12] == 3'd0)
            regs_m[cur_ins[11:7]] <= regs_m[cur_ins[19:15]] + cur_imm;
          else if (cur_ins[14:12] == 3'd6)
            regs_m[cur_ins[11:7]] <= regs_m[cur_ins[19:15]] | cur_imm;
        end
        pc_m <= pc_m + 32'd4;
      end
    end
  end

  typedef struct packed {
    logic [31:0] exp7_pre;
    logic        exp7_en;
    logic [31:0] exp7;
    logic        exp12_en;
    logic [31:0] exp12;
    logic        bad_imem;
    logic        x0_case;
    logic [31:0] budget;
    logic [8:0]  halt_idx;
    logic [5:0]  mm;
    logic [4:0]  ff;
    logic        pass;
    logic        halted;
    logic        lerr;
    logic [11:0] runs;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    vec_count++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [8:0] a,
                          input logic [31:0] d);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_addr  = a;
    cmd_data  = d;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end else begin
      checkOutput("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    model_clear = 1'b1;
    cmd_valid   = 1'b0;
    repeat (2) @(negedge clk);
    reset       = 1'b1;
    model_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000; i++) begin
      if (done) break;
      @(negedge clk);
    end
    checkOutput("done", 32'(done), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    send_cmd(2'd0, 9'd0, 32'h00a28393);
    send_cmd(2'd0, 9'd1, 32'h00436613);
    if (v.bad_imem) send_cmd(2'd0, 9'd256, 32'hdeadbeef);
    send_cmd(2'd1, 9'd5, 32'd1);
    send_cmd(2'd1, 9'd6, 32'd2);
    if (v.x0_case) begin
      send_cmd(2'd1, 9'd0, 32'hffffffff);
      send_cmd(2'd2, 9'd0, 32'd0);
    end
    if (v.exp7_pre != 32'd0) send_cmd(2'd2, 9'd7, v.exp7_pre);
    if (v.exp7_en) send_cmd(2'd2, 9'd7, v.exp7);
    if (v.exp12_en) send_cmd(2'd2, 9'd12, v.exp12);
    send_cmd(2'd3, v.halt_idx, v.budget);
    wait_done();
  endtask

  initial begin
    // exp7_pre, exp7_en, exp7, exp12_en, exp12, bad, x0, budget, halt, mm, ff, pass, halted, lerr, runs
    vecs[0] = '{32'h0,  1'b1, 32'hB, 1'b1, 32'h6, 1'b0, 1'b0, 32'd2, 9'd256, 6'd0, 5'd0,  1'b1, 1'b0, 1'b0, 12'd2};
    vecs[1] = '{32'h0,  1'b1, 32'hC, 1'b1, 32'h7, 1'b0, 1'b0, 32'd2, 9'd256, 6'd2, 5'd7,  1'b0, 1'b0, 1'b0, 12'd2};
    vecs[2] = '{32'h0,  1'b1, 32'hB, 1'b1, 32'h6, 1'b1, 1'b0, 32'd2, 9'd256, 6'd0, 5'd0,  1'b0, 1'b0, 1'b1, 12'd2};
    vecs[3] = '{32'h0,  1'b1, 32'hB, 1'b1, 32'h6, 1'b0, 1'b1, 32'd2, 9'd256, 6'd0, 5'd0,  1'b1, 1'b0, 1'b0, 12'd2};
    vecs[4] = '{32'h0,  1'b1, 32'hB, 1'b1, 32'h6, 1'b0, 1'b0, 32'd0, 9'd1,   6'd0, 5'd0,  1'b1, 1'b1, 1'b0, 12'd2};
    vecs[5] = '{32'h0,  1'b1, 32'hB, 1'b1, 32'h6, 1'b0, 1'b0, 32'd1, 9'd256, 6'd1, 5'd12, 1'b0, 1'b0, 1'b0, 12'd1};
    vecs[6] = '{32'h0,  1'b1, 32'hB, 1'b1, 32'h6, 1'b0, 1'b0, 32'd2, 9'd1,   6'd0, 5'd0,  1'b1, 1'b1, 1'b0, 12'd2};
    vecs[7] = '{32'h55, 1'b1, 32'hB, 1'b1, 32'h6, 1'b0, 1'b0, 32'd2, 9'd256, 6'd0, 5'd0,  1'b1, 1'b0, 1'b0, 12'd2};
    vecs[8] = '{32'h0,  1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd1, 9'd256, 6'd0, 5'd0,  1'b1, 1'b0, 1'b0, 12'd1};
    vecs[9] = '{32'h0,  1'b1, 32'hB, 1'b1, 32'h6, 1'b0, 1'b0, 32'd0, 9'd256, 6'd0, 5'd0,  1'b1, 1'b0, 1'b0, 12'd1024};

    // Reset state while reset is held low.
    repeat (2) @(negedge clk);
    checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
    checkOutput("rst_core_run", 32'(core_run), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_load_err", 32'(load_err), 32'd0);
    checkOutput("rst_mismatch", 32'(mismatch_count), 32'd0);
    checkOutput("rst_first_fail", 32'(first_fail_reg), 32'd0);
    checkOutput("rst_we", 32'({imem_we, rf_we}), 32'd0);
    reset       = 1'b1;
    model_clear = 1'b0;
    @(negedge clk);
    checkOutput("load_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("load_core_reset", 32'(core_reset), 32'd1);

    // Write strobes appear one cycle after the handshake, for one cycle.
    cmd_valid = 1'b1; cmd_type = 2'd0; cmd_addr = 9'd3; cmd_data = 32'h12345678;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("imem_we_pulse", 32'(imem_we), 32'd1);
    checkOutput("imem_addr", 32'(imem_addr), 32'd3);
    checkOutput("imem_wdata", imem_wdata, 32'h12345678);
    @(negedge clk);
    checkOutput("imem_we_drop", 32'(imem_we), 32'd0);
    cmd_valid = 1'b1; cmd_type = 2'd1; cmd_addr = 9'd9; cmd_data = 32'hcafe0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("rf_we_pulse", 32'(rf_we), 32'd1);
    checkOutput("rf_waddr", 32'(rf_waddr), 32'd9);
    checkOutput("rf_wdata", rf_wdata, 32'hcafe0001);
    @(negedge clk);
    checkOutput("rf_we_drop", 32'(rf_we), 32'd0);

    for (int k = 0; k < 10; k++) begin
      do_reset();
      applyStimulus(vecs[k]);
      checkOutput($sformatf("v%0d_pass", k), 32'(pass), 32'(vecs[k].pass));
      checkOutput($sformatf("v%0d_mismatch", k), 32'(mismatch_count), 32'(vecs[k].mm));
      checkOutput($sformatf("v%0d_first_fail", k), 32'(first_fail_reg), 32'(vecs[k].ff));
      checkOutput($sformatf("v%0d_halted", k), 32'(halted), 32'(vecs[k].halted));
      checkOutput($sformatf("v%0d_load_err", k), 32'(load_err), 32'(vecs[k].lerr));
      checkOutput($sformatf("v%0d_run_cycles", k), 32'(run_count), 32'(vecs[k].runs));
      checkOutput($sformatf("v%0d_x0_writes", k), 32'(x0_writes), 32'd0);
      checkOutput($sformatf("v%0d_done_cmd_ready", k), 32'(cmd_ready), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput($sformatf("v%0d_done_held", k), 32'({done, pass}), 32'({1'b1, vecs[k].pass}));
    end

    // Reset during RUN aborts and clears the expect mask.
    do_reset();
    send_cmd(2'd2, 9'd7, 32'h99);
    send_cmd(2'd3, 9'd256, 32'd100);
    repeat (5) @(negedge clk);
    checkOutput("midrun_core_run", 32'(core_run), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_core_reset", 32'(core_reset), 32'd1);
    checkOutput("abort_core_run", 32'(core_run), 32'd0);
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(vecs[8]);
    checkOutput("reload_pass", 32'(pass), 32'd1);
    checkOutput("reload_mismatch", 32'(mismatch_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/core_test_sequencer.md
Name: core_test_sequencer

Overview:
Synthesizable self-checking harness controller for the single-cycle riscv_processor core.
- Accepts a command stream that loads instruction memory, presets registers and records expected register values.
- Runs the core for a bounded cycle budget or until a halt PC is reached.
- Sweeps the register file against expectations and reports a pass/fail verdict.
- Replaces ad-hoc hierarchical pokes in benches and on-board bring-up.

Parameters:
XLEN, 32, datapath and register width
IMEM_DEPTH, 256, instruction memory depth in words
IMEM_AW, 8, word-address width (log2 IMEM_DEPTH)
NUM_REGS, 32, architectural register count
MAX_CYCLES, 1024, run budget used when START carries budget 0

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_type  in  2  0=IMEM, 1=PRESET, 2=EXPECT, 3=START
cmd_addr  in  IMEM_AW+1  word address, register index, or halt word index for START
cmd_data  in  XLEN  word or register value; for START, the cycle budget
imem_we / imem_addr / imem_wdata  out  1/IMEM_AW/XLEN  core instruction-memory write port
rf_we / rf_waddr / rf_wdata  out  1/5/XLEN  core register-file debug write port
rf_raddr  out  5  debug read address
rf_rdata  in  XLEN  combinational read data for rf_raddr
core_reset  out  1  active-high core reset
core_run  out  1  core advances PC and writes registers only while high
pc  in  XLEN  core PC
done  out  1  verdict valid
pass  out  1  verdict
halted  out  1  run ended on halt PC
load_err  out  1  sticky: out-of-range IMEM address seen
mismatch_count  out  6  number of failing checked registers
first_fail_reg  out  5  lowest failing register index

Behaviour:
- Reset (reset==0 at a clk edge):
  - State LOAD.
  - core_reset=1, core_run=0, cmd_ready=0 during reset and 1 afterwards in LOAD.
  - All write enables 0, done/pass/halted/load_err=0, mismatch_count=0, first_fail_reg=0.
  - Expect mask cleared.
  - Reset mid-operation aborts any state identically; there is no partial verdict.
- States: LOAD -> RUN -> CHECK -> DONE. DONE is held until reset.
- LOAD:
  - cmd_ready=1. Each handshake is processed, and its write output is registered, appearing exactly 1 cycle later for 1 cycle.
  - IMEM with cmd_addr<IMEM_DEPTH: imem_we=1, imem_addr=cmd_addr[IMEM_AW-1:0], imem_wdata=cmd_data. With cmd_addr>=IMEM_DEPTH: no write, load_err<=1.
  - PRESET: rf_we=1 with rf_waddr=cmd_addr[4:0]. Index 0 is silently dropped (no rf_we).
  - EXPECT: stores cmd_data in exp[cmd_addr[4:0]] and sets mask bit. A later EXPECT to the same index overwrites it. EXPECT x0 is legal.
  - START: budget<=(cmd_data==0)?MAX_CYCLES:cmd_data; halt_idx<=cmd_addr. Next state RUN; cmd_ready drops the following cycle.
- RUN:
  - core_reset=0, core_run=1 for exactly `budget` cycles, counted by an XLEN-bit counter from 0.
  - Run ends early in the first cycle where pc[IMEM_AW+1:2]==halt_idx and halt_idx<IMEM_DEPTH; halted<=1 in that case. halt_idx>=IMEM_DEPTH disables the halt.
  - If budget expiry and halt match coincide, halted=1.
  - Then CHECK with core_run=0; core_reset stays 0 so register contents are preserved.
- CHECK:
  - One register per cycle, i=0..NUM_REGS-1 (NUM_REGS cycles): rf_raddr=i, compare rf_rdata with exp[i] in the same cycle.
  - A mismatch with the mask bit set increments mismatch_count (saturating at 63). The first such i is latched into first_fail_reg.
  - Unmasked entries are never failures.
- DONE:
  - Entered the cycle after the last compare.
  - done=1 and pass=(mismatch_count==0)&&!load_err.
  - The pass formula is unaffected by halted.
  - All outputs are held stable and commands are not accepted.
- Worst-case latency, START to done: budget+NUM_REGS+1 cycles.

Decomposition:
- Shared package core_test_pkg holds:
  - cmd_type encodings: CMD_IMEM, CMD_PRESET, CMD_EXPECT, CMD_START;
  - state enum ST_LOAD, ST_RUN, ST_CHECK, ST_DONE;
  - XLEN and register-index width constants.
- One natural sub-module, expect_store: NUM_REGS x XLEN expected-value array plus mask, with a single write port and a combinational read indexed by the sweep counter.

Test Plan:
- Load 0x00a28393 (ADDI x7,x5,10) at 0 and 0x00436613 (ORI x12,x6,4) at 1; PRESET x5=1, x6=2; EXPECT x7=0xB, x12=0x6; START budget 2, halt_idx 256 -> core_run high exactly 2 cycles, done=1, pass=1, mismatch_count=0, halted=0.
- Same program with EXPECT x7=0xC and x12=0x7 -> mismatch_count=2, first_fail_reg=7, pass=0.
- IMEM command at cmd_addr=256 -> no imem_we, load_err=1; after an otherwise passing run, pass=0.
- PRESET x0=0xFFFF_FFFF -> rf_we never asserted; EXPECT x0=0 -> check passes.
- Two-instruction program, START with budget 0 and halt_idx 1 -> run stops when pc=0x4, halted=1, run lasts 2 cycles, not MAX_CYCLES.
- reset driven low during RUN -> next cycle state LOAD, core_reset=1, core_run=0, done=0, mask cleared; a reloaded test then passes normally.
